// File: rtl/div_issue_queue.sv
// In-order issue queue feeding a single shared divider; one division in flight.
// Optional macro DIV_BYPASS_EN retires divide-by-0/1 entries without using the divider.
module div_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      dividend_i,
  input  logic [31:0]      divisor_i,
  input  logic [1:0]       ops_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [31:0]      div_dividend_o,
  output logic [31:0]      div_divisor_o,
  output logic [1:0]       div_ops_o,
  output logic             is_division_o,
  input  logic [1:0]       fu_state_i,
  input  logic [31:0]      div_result_i,
  input  logic             div_by_zero_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] result_tag_o,
  output logic             div_by_zero_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;
  typedef enum logic [1:0] {FU_FREE = 2'b00, FU_BUSY = 2'b01, FU_VALID = 2'b10} fu_t;

  typedef struct packed {
    logic [31:0]      dividend;
    logic [31:0]      divisor;
    logic [1:0]       ops;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [TAG_W-1:0] iss_tag;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign ready_o = !full;
  assign push    = valid_i && !full;
  assign head    = mem[rd_ptr[PW-1:0]];
  // Head leaves the queue only when the divider is free and the result slot is (or becomes) empty.
  assign pop     = !empty && (fu_state_i == FU_FREE) &&
                   ((state == S_IDLE) || ((state == S_RETIRE) && result_ready_i));

`ifdef DIV_BYPASS_EN
  logic        take_bypass;
  logic        bypass_dbz;
  logic [31:0] bypass_result;

  assign take_bypass = (head.divisor[31:1] == '0);
  always_comb begin
    bypass_dbz = ~head.divisor[0];
    if (bypass_dbz) bypass_result = head.ops[1] ? head.dividend : '1;
    else            bypass_result = head.ops[1] ? '0 : head.dividend;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (clk_en_i && push)
      mem[wr_ptr[PW-1:0]] <= '{dividend: dividend_i, divisor: divisor_i, ops: ops_i, tag: tag_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      iss_tag        <= '0;
      is_division_o  <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_ops_o      <= '0;
      result_valid_o <= 1'b0;
      result_o       <= '0;
      result_tag_o   <= '0;
      div_by_zero_o  <= 1'b0;
    end else if (clk_en_i) begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case (state)
        S_IDLE, S_RETIRE: begin
          if ((state == S_RETIRE) && result_ready_i) begin
            state          <= S_IDLE;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            result_tag_o   <= '0;
            div_by_zero_o  <= 1'b0;
          end
          if (pop) begin
`ifdef DIV_BYPASS_EN
            if (take_bypass) begin
              state          <= S_RETIRE;
              result_valid_o <= 1'b1;
              result_o       <= bypass_result;
              result_tag_o   <= head.tag;
              div_by_zero_o  <= bypass_dbz;
            end else begin
`endif
              state          <= S_ISSUE;
              is_division_o  <= 1'b1;
              div_dividend_o <= head.dividend;
              div_divisor_o  <= head.divisor;
              div_ops_o      <= head.ops;
              iss_tag        <= head.tag;
`ifdef DIV_BYPASS_EN
            end
`endif
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (fu_state_i == FU_VALID) begin
            state          <= S_RETIRE;
            is_division_o  <= 1'b0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            div_ops_o      <= '0;
            result_valid_o <= 1'b1;
            result_o       <= div_result_i;
            result_tag_o   <= iss_tag;
            div_by_zero_o  <= div_by_zero_i;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/div_issue_queue.md
DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 5, width of destination tag.
REQ-003 SHALL have clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have clk_en_i  in  1  clock enable; when low all state holds.
REQ-006 SHALL have valid_i / ready_o  in / out  1 / 1  upstream issue handshake.
REQ-007 SHALL have dividend_i, divisor_i  in  32 each  operands.
REQ-008 SHALL have ops_i  in  2  op: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 SHALL have tag_i  in  TAG_W  destination tag carried to result.
REQ-010 SHALL have div_dividend_o, div_divisor_o  out  32 each  divider operands.
REQ-011 SHALL have div_ops_o  out  2  divider op; is_division_o  out  1  divider start/hold.
REQ-012 SHALL have fu_state_i  in  2  divider state: 00 FREE, 01 BUSY, 10 VALID.
REQ-013 SHALL have div_result_i  in  32, div_by_zero_i  in  1  divider outputs.
REQ-014 SHALL have result_valid_o / result_ready_i  out / in  1 / 1  writeback handshake.
REQ-015 SHALL have result_o  out  32, result_tag_o  out  TAG_W, div_by_zero_o  out  1.

Function
REQ-016 Queue: FIFO of {dividend, divisor, ops, tag}; push when valid_i && ready_o; ready_o = !full.
REQ-017 Pointers wrap modulo DEPTH; full/empty via extra pointer MSB; simultaneous push and pop at full or empty SHALL keep count correct (push at full refused).
REQ-018 FSM states IDLE, ISSUE, WAIT, RETIRE.
REQ-019 IDLE -> ISSUE when queue non-empty and fu_state_i == FREE; head popped into issue register that cycle.
REQ-020 ISSUE: is_division_o = 1, div_* driven from issue register; -> WAIT next cycle.
REQ-021 WAIT: is_division_o stays 1, operands stable; on fu_state_i == VALID capture div_result_i, div_by_zero_i, tag into result register, drop is_division_o, -> RETIRE.
REQ-022 RETIRE: result_valid_o = 1, result_o/result_tag_o/div_by_zero_o stable until result_ready_i; on accept -> ISSUE directly if queue non-empty and fu_state_i == FREE, else IDLE.
REQ-023 Outside ISSUE/WAIT is_division_o = 0 and div_* outputs = 0.
REQ-024 Exactly one division in flight; results returned strictly in push order.
REQ-025 fu_state_i == VALID outside WAIT SHALL be ignored.
REQ-026 Issue-to-result latency = divider latency + 1 cycle; push-to-ISSUE minimum 1 cycle after push when idle.
REQ-027 Throughput: no bubble beyond one cycle between result accept and next ISSUE.

Reset
REQ-028 On rst_n_i low, asynchronously: FSM IDLE, pointers/count 0, ready_o 1, result_valid_o 0, is_division_o 0, all data outputs 0.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight entries; no result issued for them.
REQ-030 clk_en_i low SHALL freeze state but not block asynchronous reset.

Configuration
REQ-031 Macro DIV_BYPASS_EN: when defined, at IDLE/RETIRE pop, entries with divisor 0 or divisor 1 SHALL skip the divider and go directly to RETIRE next cycle.
REQ-032 Bypass results: divisor 0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU = dividend, div_by_zero_o 1; divisor 1 -> DIV/DIVU = dividend, REM/REMU 0, div_by_zero_o 0.
REQ-033 Without DIV_BYPASS_EN all entries SHALL go through ISSUE/WAIT; bypass logic absent.

Verification
REQ-034 Single op: push DIV 100/5 tag 3, divider returns 20 -> result_valid_o with result_o 20, result_tag_o 3, once.
REQ-035 Back-to-back: push 4 ops (900 REM 5, -80 DIV 5, -402 REM 5, -33 DIVU 8) tags 1..4 -> ready_o low after 4th; results 0, -16, -2, 0x1FFFFFFB in tag order 1..4.
REQ-036 Backpressure: hold result_ready_i low 10 cycles in RETIRE -> result_o/tag stable, is_division_o 0, no new ISSUE until accept.
REQ-037 Divide by zero: push DIV -80/0 tag 7 -> result 0xFFFFFFFF, div_by_zero_o 1; with DIV_BYPASS_EN result appears 1 cycle after pop and is_division_o never asserts.
REQ-038 Reset mid-WAIT with 3 entries queued -> all outputs at reset values next edge, no result_valid_o afterwards, ready_o 1.
REQ-039 Full corner: at DEPTH entries, valid_i high with same-cycle pop -> push refused that cycle, count DEPTH-1, next cycle ready_o 1.
